integral_image_gen: RTL and testbench
=====================================

Name: integral_image_gen

Overview:
- Downstream consumer of the image buffer.
- After a start pulse it scans the stored IMG_WIDTH x IMG_HEIGHT image in raster order by issuing addresses to the buffer's addr channel and taking pixels from its data channel.
- It emits the integral image (running 2-D prefix sum) as a valid/ready stream with end-of-transfer marking.
- The output feeds the classifier's feature-evaluation stage.

Parameters:
- W_DATA, 8, pixel width.
- IMG_WIDTH, 45, image columns.
- IMG_HEIGHT, 45, image rows.
- MAX_INFLIGHT, 2, maximum addresses accepted by the buffer without a returned pixel (1..4).
- Localparams: DEPTH = IMG_WIDTH*IMG_HEIGHT; W_ADDR = $clog2(DEPTH); W_II = W_DATA + $clog2(DEPTH); W_SQ = 2*W_DATA + $clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse in the cycle after the last ii handshake.
- addr_valid  out  1  address request to the image buffer.
- addr_ready  in  1  image buffer accepts the address.
- addr_data  out  W_ADDR  linear pixel address y*IMG_WIDTH+x.
- pix_valid  in  1  pixel returned by the image buffer.
- pix_ready  out  1  block accepts the pixel.
- pix_data  in  W_DATA  pixel value.
- ii_valid  out  1  integral value valid.
- ii_ready  in  1  downstream accepts.
- ii_data  out  W_II  ii(x,y) = sum of p(i,j) for i<=x, j<=y.
- ii_eot  out  1  high with the final value (x=IMG_WIDTH-1, y=IMG_HEIGHT-1).
- sq_data  out  W_SQ  squared integral; present only under SQ_INTEGRAL_EN.

Behaviour:
- Reset values (when rst=0): busy, done, addr_valid, ii_valid and ii_eot are 0; ii_data and sq_data are 0; state is IDLE; all counters are 0.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE -> SCAN on start; address counter and pixel x/y counters are cleared.
  - SCAN -> DRAIN on the addr handshake of address DEPTH-1.
  - DRAIN -> IDLE on the ii handshake with ii_eot=1; done pulses in the following cycle.
  - start while busy is ignored.
- Address issue: addr_valid = (state==SCAN) && (inflight < MAX_INFLIGHT).
  - addr_data increments by 1 per addr handshake, in raster order.
  - addr_valid/addr_data hold stable until the handshake completes.
- Inflight counter: +1 on addr handshake, -1 on pix handshake; both in the same cycle leaves it unchanged. It never exceeds MAX_INFLIGHT and never underflows.
- pix_ready = !ii_valid || ii_ready (single output register, no bubble).
- On pix handshake:
  - row_sum <= (x==0 ? 0 : row_sum) + pix.
  - ii = row_sum_new + (y==0 ? 0 : line[x]).
  - line[x] <= ii.
  - The ii output register loads ii, and ii_eot loads 1 if this is the last pixel.
  - x/y advance; x wraps to 0 at IMG_WIDTH-1 and y increments.
  - Latency: pixel handshake to ii_valid is one cycle.
- ii_valid stays high, with ii_data/ii_eot stable, until ii_ready. When ii_valid=1 and ii_ready=0, pix_ready=0.
- Arithmetic is unsigned. row_sum is W_DATA+$clog2(IMG_WIDTH+1) bits. W_II cannot overflow at full-scale input.
- Line buffer: IMG_WIDTH x W_II, read and written at the same index in the same cycle (read old value, write new). No clear is needed because row 0 masks the read.
- Reset mid-scan returns to IDLE immediately and drops inflight. The upstream buffer is reset with the same rst.
- Pixels arriving in IDLE are not possible by protocol. pix_ready is still driven by the rule above.

Optional Feature:
- Macro SQ_INTEGRAL_EN.
- Defined:
  - A second accumulator path computes the squared integral image: sum of p^2, with pix*pix (2*W_DATA bits) as the increment.
  - A parallel W_SQ line buffer is added.
  - sq_data is a port, updated and held under exactly the same handshake as ii_data.
- Undefined: the sq_data port, the multiplier and the second line buffer are absent. All other behaviour is identical.

Decomposition:
- Package cc_pkg holds:
  - the state enum typedef (IDLE, SCAN, DRAIN);
  - functions computing W_ADDR, W_II and W_SQ from the parameters.
- One sub-module, ii_line_buf: a parameterised width/depth register array with same-cycle read-old/write. It is instantiated once for ii and once more under SQ_INTEGRAL_EN.

Test Plan:
- 3x3 image all ones, ii_ready=1, 1-cycle buffer model -> ii stream 1,2,3,2,4,6,3,6,9; ii_eot only on 9; done one cycle after the last handshake.
- 45x45 all 255 -> final ii_data=516375 with ii_eot; under SQ_INTEGRAL_EN, sq_data=131675625; exactly 2025 output handshakes.
- 3x3 pixels 1..9 raster, ii_ready toggling 1/0 every cycle -> values 1,3,6,5,12,21,12,27,45 with no loss or duplication; data held stable while stalled.
- Buffer model holds addr_ready=0 for 5 cycles mid-scan -> addr_data stable; inflight never exceeds MAX_INFLIGHT=2; output sequence unchanged.
- start pulsed during SCAN -> ignored; a second start after done re-scans and gives an identical stream (line buffer not cleared, row-0 masking verified).
- rst asserted after 10 outputs -> busy, ii_valid and addr_valid are 0 asynchronously; a new start yields the full correct stream from ii(0,0).

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and width helpers for the integral image generator.
// Combinational only; no flow control.
// Width helpers take the pixel count so every file derives identical bus sizes.
package cc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int calc_w_addr(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_w_ii(input int w_data, input int depth);
        return w_data + $clog2(depth);
    endfunction

    function automatic int calc_w_sq(input int w_data, input int depth);
        return 2 * w_data + $clog2(depth);
    endfunction

endpackage

// File: rtl/ii_line_buf.sv
// One-row line store of previous-row integral values, indexed by column.
// Read is combinational (old value); the write lands at the clock edge.
// No flow control: the owner decides when to write.
module ii_line_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int W_IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [W_IDX-1:0] idx,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_dat = mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_dat;
        end
    end

endmodule

// File: rtl/integral_image_gen.sv
// Raster-scans the image buffer and streams the 2-D prefix sum; SQ_INTEGRAL_EN adds a squared sum.
// Latency: one cycle from pixel handshake to ii_valid.
// Backpressure: ii_ready low holds the output and stalls pix_ready; addresses are capped by MAX_INFLIGHT.
module integral_image_gen
    import cc_pkg::*;
#(
    parameter int W_DATA       = 8,
    parameter int IMG_WIDTH    = 45,
    parameter int IMG_HEIGHT   = 45,
    parameter int MAX_INFLIGHT = 2,
    localparam int DEPTH  = IMG_WIDTH * IMG_HEIGHT,
    localparam int W_ADDR = calc_w_addr(DEPTH),
    localparam int W_II   = calc_w_ii(W_DATA, DEPTH)
`ifdef SQ_INTEGRAL_EN
    ,
    localparam int W_SQ   = calc_w_sq(W_DATA, DEPTH)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [W_ADDR-1:0] addr_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [W_DATA-1:0] pix_data,
    output logic              ii_valid,
    input  logic              ii_ready,
    output logic [W_II-1:0]   ii_data,
    output logic              ii_eot
`ifdef SQ_INTEGRAL_EN
    ,
    output logic [W_SQ-1:0]   sq_data
`endif
);

    localparam int W_X   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int W_Y   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int W_INF = $clog2(MAX_INFLIGHT + 1);
    localparam int W_ROW = W_DATA + $clog2(IMG_WIDTH + 1);

    state_t            state, state_nxt;
    logic              scan_start, done_set;
    logic [W_ADDR-1:0] addr_cnt;
    logic [W_INF-1:0]  inflight;
    logic [W_X-1:0]    x;
    logic [W_Y-1:0]    y;
    logic [W_ROW-1:0]  row_sum, row_base, row_sum_nxt;
    logic [W_II-1:0]   line_rd, ii_nxt;
    logic              addr_hs, pix_hs, ii_hs, last_pix;

    assign busy       = (state != IDLE);
    assign addr_valid = (state == SCAN) && (inflight < W_INF'(MAX_INFLIGHT));
    assign addr_data  = addr_cnt;
    assign pix_ready  = !ii_valid || ii_ready;
    assign addr_hs    = addr_valid && addr_ready;
    assign pix_hs     = pix_valid && pix_ready;
    assign ii_hs      = ii_valid && ii_ready;
    assign last_pix   = (x == W_X'(IMG_WIDTH - 1)) && (y == W_Y'(IMG_HEIGHT - 1));

    always_comb begin
        state_nxt  = state;
        scan_start = 1'b0;
        done_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SCAN;
                    scan_start = 1'b1;
                end
            end
            SCAN: begin
                if (addr_hs && (addr_cnt == W_ADDR'(DEPTH - 1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (ii_hs && ii_eot) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt <= '0;
        end else if (scan_start) begin
            addr_cnt <= '0;
        end else if (addr_hs) begin
            addr_cnt <= addr_cnt + W_ADDR'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            unique case ({addr_hs, pix_hs})
                2'b10:   inflight <= inflight + W_INF'(1);
                2'b01:   inflight <= inflight - W_INF'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Column 0 restarts the row sum; row 0 masks the line buffer, so it never needs clearing.
    always_comb begin
        row_base    = (x == '0) ? '0 : row_sum;
        row_sum_nxt = row_base + W_ROW'(pix_data);
        ii_nxt      = W_II'(row_sum_nxt) + ((y == '0) ? '0 : line_rd);
    end

    ii_line_buf #(
        .WIDTH (W_II),
        .DEPTH (IMG_WIDTH)
    ) u_ii_line (
        .clk    (clk),
        .wr_en  (pix_hs),
        .idx    (x),
        .wr_dat (ii_nxt),
        .rd_dat (line_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x        <= '0;
            y        <= '0;
            row_sum  <= '0;
            ii_valid <= 1'b0;
            ii_data  <= '0;
            ii_eot   <= 1'b0;
        end else begin
            if (scan_start) begin
                x <= '0;
                y <= '0;
            end else if (pix_hs) begin
                row_sum <= row_sum_nxt;
                if (x == W_X'(IMG_WIDTH - 1)) begin
                    x <= '0;
                    y <= (y == W_Y'(IMG_HEIGHT - 1)) ? '0 : y + W_Y'(1);
                end else begin
                    x <= x + W_X'(1);
                end
            end
            if (pix_hs) begin
                ii_valid <= 1'b1;
                ii_data  <= ii_nxt;
                ii_eot   <= last_pix;
            end else if (ii_ready) begin
                ii_valid <= 1'b0;
                ii_eot   <= 1'b0;
            end
        end
    end

`ifdef SQ_INTEGRAL_EN
    localparam int W_SQROW = 2 * W_DATA + $clog2(IMG_WIDTH + 1);

    logic [2*W_DATA-1:0] pix_sq;
    logic [W_SQROW-1:0]  sq_row, sq_base, sq_row_nxt;
    logic [W_SQ-1:0]     sq_line_rd, sq_nxt;

    always_comb begin
        pix_sq     = (2*W_DATA)'(pix_data) * (2*W_DATA)'(pix_data);
        sq_base    = (x == '0) ? '0 : sq_row;
        sq_row_nxt = sq_base + W_SQROW'(pix_sq);
        sq_nxt     = W_SQ'(sq_row_nxt) + ((y == '0) ? '0 : sq_line_rd);
    end

    ii_line_buf #(
        .WIDTH (W_SQ),
        .DEPTH (IMG_WIDTH)
    ) u_sq_line (
        .clk    (clk),
        .wr_en  (pix_hs),
        .idx    (x),
        .wr_dat (sq_nxt),
        .rd_dat (sq_line_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_row  <= '0;
            sq_data <= '0;
        end else if (pix_hs) begin
            sq_row  <= sq_row_nxt;
            sq_data <= sq_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Bench for integral_image_gen: a 3x3 and a 45x45 instance, each fed by a 1-cycle image buffer model.
// Expected integral values come from an inclusion-exclusion prefix model and are queued before each scan.
module tb_integral_image_gen;

    localparam int MAXI = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int     img [0:2024];
    longint exp_d[$], exp_sq[$];
    longint got_d[$], got_sq[$];
    bit     got_e[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    // 3x3 instance
    logic        s_start, s_busy, s_done, s_av, s_ar, s_pv, s_pr, s_iv, s_ir, s_eot;
    logic [3:0]  s_ad;
    logic [7:0]  s_pd;
    logic [11:0] s_id;
    logic [19:0] s_sq;
    logic [7:0]  s_q[$];

    // 45x45 instance
    logic        l_start, l_busy, l_done, l_av, l_ar, l_pv, l_pr, l_iv, l_ir, l_eot;
    logic [10:0] l_ad;
    logic [7:0]  l_pd;
    logic [18:0] l_id;
    logic [26:0] l_sq;
    logic [7:0]  l_q[$];

    integral_image_gen #(.W_DATA(8), .IMG_WIDTH(3), .IMG_HEIGHT(3), .MAX_INFLIGHT(MAXI)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .addr_valid(s_av), .addr_ready(s_ar), .addr_data(s_ad),
        .pix_valid(s_pv), .pix_ready(s_pr), .pix_data(s_pd),
`ifdef SQ_INTEGRAL_EN
        .sq_data(s_sq),
`endif
        .ii_valid(s_iv), .ii_ready(s_ir), .ii_data(s_id), .ii_eot(s_eot)
    );

    integral_image_gen #(.W_DATA(8), .IMG_WIDTH(45), .IMG_HEIGHT(45), .MAX_INFLIGHT(MAXI)) dut_l (
        .clk(clk), .rst(rst), .start(l_start), .busy(l_busy), .done(l_done),
        .addr_valid(l_av), .addr_ready(l_ar), .addr_data(l_ad),
        .pix_valid(l_pv), .pix_ready(l_pr), .pix_data(l_pd),
`ifdef SQ_INTEGRAL_EN
        .sq_data(l_sq),
`endif
        .ii_valid(l_iv), .ii_ready(l_ir), .ii_data(l_id), .ii_eot(l_eot)
    );

`ifndef SQ_INTEGRAL_EN
    assign s_sq = '0;
    assign l_sq = '0;
`endif

    // Image buffer models: pixel returned the cycle after the address handshake.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q.delete();
            s_pv <= 1'b0;
            s_pd <= 8'd0;
        end else begin
            if (s_pv && s_pr) void'(s_q.pop_front());
            if (s_av && s_ar) s_q.push_back(8'(img[s_ad]));
            s_pv <= (s_q.size() != 0);
            s_pd <= (s_q.size() != 0) ? s_q[0] : 8'd0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_q.delete();
            l_pv <= 1'b0;
            l_pd <= 8'd0;
        end else begin
            if (l_pv && l_pr) void'(l_q.pop_front());
            if (l_av && l_ar) l_q.push_back(8'(img[l_ad]));
            l_pv <= (l_q.size() != 0);
            l_pd <= (l_q.size() != 0) ? l_q[0] : 8'd0;
        end
    end

    // Protocol monitor on the 3x3 address channel.
    int         s_inf      = 0;
    int         s_inf_max  = 0;
    int         s_inf_err  = 0;
    int         s_addr_err = 0;
    logic       s_prev_stall = 1'b0;
    logic [3:0] s_prev_addr  = 4'd0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_inf        <= 0;
            s_prev_stall <= 1'b0;
        end else begin
            s_inf <= s_inf + ((s_av && s_ar) ? 1 : 0) - ((s_pv && s_pr) ? 1 : 0);
            if (s_inf > s_inf_max) s_inf_max <= s_inf;
            if (s_inf > MAXI || s_inf < 0) s_inf_err <= s_inf_err + 1;
            if (s_prev_stall && (!s_av || s_ad != s_prev_addr)) s_addr_err <= s_addr_err + 1;
            s_prev_stall <= s_av && !s_ar;
            s_prev_addr  <= s_ad;
        end
    end

    task automatic push_exp(input int w, input int h);
        longint a [0:44][0:44];
        longint q [0:44][0:44];
        longint p;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                p = longint'(img[yy*w+xx]);
                a[yy][xx] = p;
                q[yy][xx] = p * p;
                if (xx > 0) begin a[yy][xx] += a[yy][xx-1]; q[yy][xx] += q[yy][xx-1]; end
                if (yy > 0) begin a[yy][xx] += a[yy-1][xx]; q[yy][xx] += q[yy-1][xx]; end
                if (xx > 0 && yy > 0) begin a[yy][xx] -= a[yy-1][xx-1]; q[yy][xx] -= q[yy-1][xx-1]; end
                exp_d.push_back(a[yy][xx]);
                exp_sq.push_back(q[yy][xx]);
            end
        end
    endtask

    task automatic pulse_start_s();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
    endtask

    task automatic pulse_start_l();
        @(negedge clk); l_start = 1'b1;
        @(negedge clk); l_start = 1'b0;
    endtask

    // Drives the 3x3 output/address channels and records every output handshake.
    task automatic collect_s(input bit toggle, input int stall_at, input int start_at,
                             output int n_hs, output bit done_ok, output int stable_err, output bit timed_out);
        bit          held;
        logic [11:0] held_d;
        logic        held_e;
        int          post;
        got_d.delete(); got_e.delete(); got_sq.delete();
        n_hs = 0; done_ok = 1'b0; stable_err = 0; timed_out = 1'b1;
        held = 1'b0; held_d = '0; held_e = 1'b0; post = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (post >= 0) post++;
            if (post == 1) done_ok = (s_done === 1'b1) && (s_busy === 1'b0);
            if (post == 2) begin
                done_ok   = done_ok && (s_done === 1'b0);
                timed_out = 1'b0;
                break;
            end
            s_ir    = toggle ? (cyc % 2 == 0) : 1'b1;
            s_ar    = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            s_start = (cyc == start_at);
            if (held && (s_iv !== 1'b1 || s_id !== held_d || s_eot !== held_e)) stable_err++;
            held   = s_iv && !s_ir;
            held_d = s_id;
            held_e = s_eot;
            if (s_iv && s_ir) begin
                got_d.push_back(longint'(s_id));
                got_e.push_back(s_eot);
                got_sq.push_back(longint'(s_sq));
                n_hs++;
                if (s_eot) post = 0;
            end
        end
        s_ir = 1'b1; s_ar = 1'b1; s_start = 1'b0;
    endtask

    task automatic collect_l(input int max_out, output int n_hs, output bit timed_out);
        got_d.delete(); got_e.delete(); got_sq.delete();
        n_hs = 0; timed_out = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (l_iv && l_ir) begin
                got_d.push_back(longint'(l_id));
                got_e.push_back(l_eot);
                got_sq.push_back(longint'(l_sq));
                n_hs++;
                if (l_eot || n_hs == max_out) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        n_assert++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual %0d required 0", s_busy); end
        n_assert++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: actual %0d required 0", s_done); end
        n_assert++; if (s_av !== 1'b0) begin n_fail++; $display("FAIL reset_addr_valid: actual %0d required 0", s_av); end
        n_assert++; if (s_iv !== 1'b0) begin n_fail++; $display("FAIL reset_ii_valid: actual %0d required 0", s_iv); end
        n_assert++; if (s_eot !== 1'b0) begin n_fail++; $display("FAIL reset_ii_eot: actual %0d required 0", s_eot); end
        n_assert++; if (s_id !== 12'd0) begin n_fail++; $display("FAIL reset_ii_data: actual %0d required 0", s_id); end
        n_assert++; if (s_sq !== 20'd0) begin n_fail++; $display("FAIL reset_sq_data: actual %0d required 0", s_sq); end
        n_assert++; if (l_busy !== 1'b0) begin n_fail++; $display("FAIL reset_l_busy: actual %0d required 0", l_busy); end
    endtask

    task automatic test_ones_3x3();
        int n, serr; bit dok, to; longint e, es;
        for (int i = 0; i < 9; i++) img[i] = 1;
        push_exp(3, 3);
        pulse_start_s();
        n_assert++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL ones_busy: actual %0d required 1", s_busy); end
        collect_s(1'b0, -1, -1, n, dok, serr, to);
        n_assert++; if (to) begin n_fail++; $display("FAIL ones_timeout: actual 1 required 0"); end
        n_assert++; if (n != 9) begin n_fail++; $display("FAIL ones_count: actual %0d required 9", n); end
        for (int i = 0; i < n && i < 9; i++) begin
            e = exp_d.pop_front(); es = exp_sq.pop_front();
            n_assert++; if (got_d[i] !== e) begin n_fail++; $display("FAIL ones_ii[%0d]: actual %0d required %0d", i, got_d[i], e); end
            n_assert++; if (got_e[i] !== (i == 8)) begin n_fail++; $display("FAIL ones_eot[%0d]: actual %0d required %0d", i, got_e[i], i == 8); end
`ifdef SQ_INTEGRAL_EN
            n_assert++; if (got_sq[i] !== es) begin n_fail++; $display("FAIL ones_sq[%0d]: actual %0d required %0d", i, got_sq[i], es); end
`endif
        end
        n_assert++; if (!dok) begin n_fail++; $display("FAIL ones_done_pulse: actual 0 required 1"); end
        exp_d.delete(); exp_sq.delete();
    endtask

    task automatic test_full_scale();
        int n, bad, eots; bit to; longint e, es, last_d, last_sq; bit last_e;
        for (int i = 0; i < 2025; i++) img[i] = 255;
        push_exp(45, 45);
        pulse_start_l();
        collect_l(100000, n, to);
        n_assert++; if (to) begin n_fail++; $display("FAIL full_timeout: actual 1 required 0"); end
        n_assert++; if (n != 2025) begin n_fail++; $display("FAIL full_count: actual %0d required 2025", n); end
        bad = 0; eots = 0; last_d = 0; last_sq = 0; last_e = 1'b0;
        for (int i = 0; i < n && exp_d.size() != 0; i++) begin
            e = exp_d.pop_front(); es = exp_sq.pop_front();
            if (got_d[i] !== e) bad++;
`ifdef SQ_INTEGRAL_EN
            if (got_sq[i] !== es) bad++;
`endif
            if (got_e[i]) eots++;
            last_d = got_d[i]; last_sq = got_sq[i]; last_e = got_e[i];
        end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL full_values: actual %0d wrong required 0", bad); end
        n_assert++; if (last_d !== 64'd516375) begin n_fail++; $display("FAIL full_final_ii: actual %0d required 516375", last_d); end
        n_assert++; if (!last_e || eots != 1) begin n_fail++; $display("FAIL full_eot: actual last=%0d count=%0d required 1/1", last_e, eots); end
`ifdef SQ_INTEGRAL_EN
        n_assert++; if (last_sq !== 64'd131675625) begin n_fail++; $display("FAIL full_final_sq: actual %0d required 131675625", last_sq); end
`endif
        exp_d.delete(); exp_sq.delete();
    endtask

    task automatic test_ready_toggle();
        int n, serr; bit dok, to; longint e;
        for (int i = 0; i < 9; i++) img[i] = i + 1;
        push_exp(3, 3);
        pulse_start_s();
        collect_s(1'b1, -1, -1, n, dok, serr, to);
        n_assert++; if (to) begin n_fail++; $display("FAIL toggle_timeout: actual 1 required 0"); end
        n_assert++; if (n != 9) begin n_fail++; $display("FAIL toggle_count: actual %0d required 9", n); end
        for (int i = 0; i < n && i < 9; i++) begin
            e = exp_d.pop_front();
            n_assert++; if (got_d[i] !== e) begin n_fail++; $display("FAIL toggle_ii[%0d]: actual %0d required %0d", i, got_d[i], e); end
        end
        n_assert++; if (serr != 0) begin n_fail++; $display("FAIL toggle_hold_stable: actual %0d changes required 0", serr); end
        n_assert++; if (!dok) begin n_fail++; $display("FAIL toggle_done_pulse: actual 0 required 1"); end
        exp_d.delete(); exp_sq.delete();
    endtask

    task automatic test_addr_stall();
        int n, serr; bit dok, to; longint e;
        for (int i = 0; i < 9; i++) img[i] = i + 1;
        push_exp(3, 3);
        pulse_start_s();
        collect_s(1'b0, 3, -1, n, dok, serr, to);
        n_assert++; if (to || n != 9) begin n_fail++; $display("FAIL stall_count: actual %0d required 9", n); end
        for (int i = 0; i < n && i < 9; i++) begin
            e = exp_d.pop_front();
            n_assert++; if (got_d[i] !== e) begin n_fail++; $display("FAIL stall_ii[%0d]: actual %0d required %0d", i, got_d[i], e); end
        end
        n_assert++; if (s_addr_err != 0) begin n_fail++; $display("FAIL stall_addr_stable: actual %0d changes required 0", s_addr_err); end
        n_assert++; if (s_inf_err != 0 || s_inf_max > MAXI) begin n_fail++; $display("FAIL stall_inflight: actual max %0d required <= %0d", s_inf_max, MAXI); end
        exp_d.delete(); exp_sq.delete();
    endtask

    task automatic test_restart();
        int n, serr; bit dok, to; longint e;
        for (int i = 0; i < 9; i++) img[i] = 10 * i + 3;
        for (int pass = 0; pass < 2; pass++) begin
            push_exp(3, 3);
            pulse_start_s();
            collect_s(1'b0, -1, (pass == 0) ? 4 : -1, n, dok, serr, to);
            n_assert++; if (to || n != 9) begin n_fail++; $display("FAIL restart_count[%0d]: actual %0d required 9", pass, n); end
            for (int i = 0; i < n && i < 9; i++) begin
                e = exp_d.pop_front();
                n_assert++; if (got_d[i] !== e) begin n_fail++; $display("FAIL restart_ii[%0d][%0d]: actual %0d required %0d", pass, i, got_d[i], e); end
            end
            n_assert++; if (!dok) begin n_fail++; $display("FAIL restart_done[%0d]: actual 0 required 1", pass); end
            exp_d.delete(); exp_sq.delete();
        end
    endtask

    task automatic test_reset_mid();
        int n, bad; bit to; longint e;
        for (int i = 0; i < 2025; i++) img[i] = (i * 37 + 11) % 256;
        push_exp(45, 45);
        pulse_start_l();
        collect_l(10, n, to);
        n_assert++; if (to || n != 10) begin n_fail++; $display("FAIL rstmid_pre_count: actual %0d required 10", n); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_assert++; if (l_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: actual %0d required 0", l_busy); end
        n_assert++; if (l_iv !== 1'b0) begin n_fail++; $display("FAIL rstmid_ii_valid: actual %0d required 0", l_iv); end
        n_assert++; if (l_av !== 1'b0) begin n_fail++; $display("FAIL rstmid_addr_valid: actual %0d required 0", l_av); end
        @(negedge clk) rst = 1'b1;
        exp_d.delete(); exp_sq.delete();
        push_exp(45, 45);
        pulse_start_l();
        collect_l(100000, n, to);
        n_assert++; if (to || n != 2025) begin n_fail++; $display("FAIL rstmid_count: actual %0d required 2025", n); end
        n_assert++; if (n == 0 || got_d[0] !== longint'(img[0])) begin n_fail++; $display("FAIL rstmid_first: actual %0d required %0d", (n == 0) ? -1 : got_d[0], img[0]); end
        bad = 0;
        for (int i = 0; i < n && exp_d.size() != 0; i++) begin
            e = exp_d.pop_front();
            if (got_d[i] !== e) bad++;
        end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_values: actual %0d wrong required 0", bad); end
        exp_d.delete(); exp_sq.delete();
    endtask

    initial begin
        rst = 1'b0;
        s_start = 1'b0; s_ar = 1'b1; s_ir = 1'b1;
        l_start = 1'b0; l_ar = 1'b1; l_ir = 1'b1;
        #12;
        test_reset();
        @(negedge clk) rst = 1'b1;
        test_ones_3x3();
        test_full_scale();
        test_ready_toggle();
        test_addr_stall();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
